// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ
// requesters. One byte is moved per grant. The start/complete handshake is
// sequenced here, and an optional watchdog forces completion if the
// transmitter hangs.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no byte in flight; pick the next requester round-robin
//   S_START | byte latched and ack issued; fire tx_start next edge
//   S_WAIT  | transmitter busy; wait for tx_done or watchdog expiry
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic [NUM_REQ-1:0]          done,
  output logic [NUM_REQ-1:0]          err,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_done,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  owner
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = 24;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
  // Last count value seen in WAIT before completion is forced.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    ptr, ptr_nxt;
  logic [WD_W-1:0]     wd_cnt, wd_nxt;
  logic [NUM_REQ-1:0]  ack_nxt, done_nxt, err_nxt;
  logic                tx_start_nxt;
  logic [DATA_W-1:0]   tx_data_nxt;
  logic [IDX_W-1:0]    owner_nxt;
  logic                busy_nxt;

  logic                found;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    owner_inc;
  int                  rr_idx;

  // Round-robin search: first requester at or after ptr, wrapping at NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    rr_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = int'(ptr) + k;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (!found && req[rr_idx[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = rr_idx[IDX_W-1:0];
      end
    end
  end

  // Pointer value after the current owner completes (modulo NUM_REQ).
  always_comb begin
    if (int'(owner) == NUM_REQ - 1) owner_inc = '0;
    else                            owner_inc = owner + 1'b1;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    wd_nxt       = wd_cnt;
    ack_nxt      = '0;
    done_nxt     = '0;
    err_nxt      = '0;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    owner_nxt    = owner;
    case (state)
      S_IDLE: begin
        // Stray tx_done pulses land here and are ignored.
        if (found) begin
          tx_data_nxt     = req_data[winner*DATA_W +: DATA_W];
          owner_nxt       = winner;
          ack_nxt[winner] = 1'b1;
          state_nxt       = S_START;
        end
      end
      S_START: begin
        tx_start_nxt = 1'b1;
        wd_nxt       = '0;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        // A real completion wins over a watchdog expiry in the same cycle.
        if (tx_done) begin
          done_nxt[owner] = 1'b1;
          ptr_nxt         = owner_inc;
          state_nxt       = S_IDLE;
        end else if (WDOG_EN && (wd_cnt == WD_LAST)) begin
          done_nxt[owner] = 1'b1;
          err_nxt[owner]  = 1'b1;
          ptr_nxt         = owner_inc;
          state_nxt       = S_IDLE;
        end else if (WDOG_EN) begin
          wd_nxt = wd_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // State, pointer, watchdog and output registers. Reset abandons any byte
  // in flight without reporting it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      ptr      <= '0;
      wd_cnt   <= '0;
      ack      <= '0;
      done     <= '0;
      err      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      owner    <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      wd_cnt   <= wd_nxt;
      ack      <= ack_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      tx_start <= tx_start_nxt;
      tx_data  <= tx_data_nxt;
      owner    <= owner_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (4 requesters, 16-cycle watchdog): a table of
// directed transfers, stray-done and mid-transfer reset sequences, then a
// randomized run against a timing-rule reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic          clock;
  logic          resetn;
  logic [N-1:0]  req;
  logic [N*8-1:0] req_data;
  logic [N-1:0]  ack, done, err;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_done;
  logic          busy;
  logic [1:0]    owner;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .done     (done),
    .err      (err),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .owner    (owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full transfer from IDLE. dly >= 0: tx_done driven dly cycles after
  // the tx_start cycle. dly < 0: tx_done withheld so the watchdog fires.
  task automatic run_txn(input string tag, input logic [3:0] r, input logic [7:0] base,
                         input int exp_own, input int dly);
    logic [3:0] oh;
    logic [7:0] expd;
    logic       early;
    int         n;
    oh   = 4'(1 << exp_own);
    expd = base ^ 8'(exp_own);
    for (int i = 0; i < N; i++) req_data[i*8 +: 8] = base ^ 8'(i);
    req = r;
    tick();
    check({tag, "_ack"}, {ack, owner, busy, tx_data, tx_start},
          {oh, 2'(exp_own), 1'b1, expd, 1'b0});
    req_data = $urandom;
    tick();
    check({tag, "_start"}, {tx_start, ack, busy, tx_data}, {1'b1, 4'b0, 1'b1, expd});
    early = 1'b0;
    n = (dly < 0) ? TO - 1 : dly;
    repeat (n) begin
      req_data = $urandom;
      tick();
      if (done != 0 || err != 0 || tx_start || !busy || tx_data !== expd) early = 1'b1;
    end
    if (dly >= 0) tx_done = 1'b1;
    req_data = $urandom;
    tick();
    tx_done = 1'b0;
    check({tag, "_hold"}, {63'b0, early}, 64'b0);
    check({tag, "_done"}, {done, err, busy, owner, tx_data},
          {oh, (dly < 0) ? oh : 4'b0, 1'b0, 2'(exp_own), expd});
  endtask

  typedef struct {
    logic [3:0] r;
    logic [7:0] base;
    int         own;
    int         dly;
  } vec_t;

  vec_t tbl[13];

  // Reference model state for the randomized run.
  bit         m_active;
  int         m_ptr, m_own, m_start, cyc;
  logic [7:0] m_data;
  logic [3:0] e_ack, e_done, e_err;
  logic       e_start;
  logic       flag;

  initial begin
    // pointer starts at 0 after reset; comments give pointer after each entry
    tbl[0]  = '{4'b0100, 8'h43, 2, 10};   // slice 2 = 8'h41, ptr 3
    tbl[1]  = '{4'b1111, 8'h10, 3, 5};    // ptr 0
    tbl[2]  = '{4'b1111, 8'h20, 0, 5};    // ptr 1
    tbl[3]  = '{4'b1111, 8'h30, 1, 5};    // ptr 2
    tbl[4]  = '{4'b1111, 8'h50, 2, 5};    // ptr 3
    tbl[5]  = '{4'b1111, 8'h60, 3, 5};    // ptr 0
    tbl[6]  = '{4'b1111, 8'h70, 0, 5};    // ptr 1
    tbl[7]  = '{4'b0010, 8'h80, 1, -1};   // timeout, ptr 2
    tbl[8]  = '{4'b0011, 8'h90, 0, 15};   // coincident done, ptr 1
    tbl[9]  = '{4'b1001, 8'hA0, 3, 0};    // ptr 0
    tbl[10] = '{4'b0110, 8'hB0, 1, 3};    // ptr 2
    tbl[11] = '{4'b0001, 8'hC0, 0, -1};   // timeout, ptr 1
    tbl[12] = '{4'b1100, 8'hD0, 2, 7};    // ptr 3

    req = '0; req_data = '0; tx_done = 1'b0;
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    check("reset", {ack, done, err, tx_start, busy, owner, tx_data}, 64'b0);

    for (int i = 0; i < 13; i++) run_txn($sformatf("tbl%0d", i), tbl[i].r, tbl[i].base, tbl[i].own, tbl[i].dly);

    // stray tx_done in IDLE: nothing happens, pointer stays at 3
    req = '0;
    flag = 1'b0;
    repeat (6) begin
      tx_done = ~tx_done;
      tick();
      if (ack != 0 || done != 0 || err != 0 || tx_start || busy) flag = 1'b1;
    end
    tx_done = 1'b0;
    check("stray", {63'b0, flag}, 64'b0);
    run_txn("after_stray", 4'b0101, 8'h11, 0, 4);     // ptr 3 -> picks 0, ptr 1

    // reset in the middle of WAIT
    req = 4'b0100;
    tick();
    req = '0;
    repeat (3) tick();
    check("mid_busy", {63'b0, busy}, 64'b1);
    #2 resetn = 1'b0;
    #1 check("async_rst", {ack, done, err, tx_start, busy, owner, tx_data}, 64'b0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    resetn = 1'b1;
    tick();
    check("post_rst", {ack, done, err, tx_start, busy, owner, tx_data}, 64'b0);
    run_txn("rst_ptr", 4'b1001, 8'h22, 0, 2);          // ptr reset to 0
    run_txn("rst_req3", 4'b1000, 8'h33, 3, 2);

    // randomized run against the model
    req = '0; tx_done = 1'b0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    m_active = 0; m_ptr = 0; m_own = 0; m_data = '0; m_start = 0; cyc = 0;
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      req_data = $urandom;
      tx_done  = ($urandom_range(0, 9) == 0);
      e_ack = '0; e_done = '0; e_err = '0; e_start = 1'b0;
      if (!m_active) begin
        if (req != 0) begin
          int w;
          w = -1;
          for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (w < 0 && req[j]) w = j;
          end
          m_own    = w;
          m_data   = req_data[w*8 +: 8];
          e_ack    = 4'(1 << w);
          m_active = 1;
          m_start  = cyc + 2;
        end
      end else if (cyc + 1 == m_start) begin
        e_start = 1'b1;
      end else if (tx_done || (cyc + 1 == m_start + TO)) begin
        e_done   = 4'(1 << m_own);
        e_err    = tx_done ? 4'b0 : e_done;
        m_active = 0;
        m_ptr    = (m_own + 1) % N;
      end
      tick();
      cyc++;
      check("rand", {ack, done, err, tx_start, busy, owner, tx_data},
            {e_ack, e_done, e_err, e_start, m_active, 2'(m_own), m_data});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
